// File: rtl/pilha_ctrl.sv
// pilha_ctrl: stack controller in front of a synchronous single-port RAM
// with 1-cycle read latency. Serves PUSH / POP / REPLACE over a valid/ready
// handshake, owns the stack pointer and reports full/empty/overflow/underflow.
// Optional macro PILHA_ERR_STICKY_EN: error flags stay set until err_clr or
// reset; when undefined they are one-cycle pulses alongside done in ERR.
module pilha_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              flush,
   input  logic              err_clr,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              err_ovf,
   output logic              err_unf,
   output logic [ADDR_W:0]   depth,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_RD      = 3'd2,
      S_RD_WAIT = 3'd3,
      S_DONE    = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   localparam logic [1:0] OP_PUSH    = 2'b01;
   localparam logic [1:0] OP_POP     = 2'b10;
   localparam logic [1:0] OP_REPLACE = 2'b11;

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] SP_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     sp_q, sp_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [ADDR_W:0]     sp_m1;
   logic                full_w, empty_w;
   logic                ovf_set, unf_set;

   // Status is purely a function of the stack pointer (sp == entry count).
   assign full_w  = (sp_q == DEPTH_C);
   assign empty_w = (sp_q == '0);
   assign sp_m1   = sp_q - SP_ONE;

   // State, stack pointer and datapath registers; reset aborts any command.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sp_q        <= '0;
         op_q        <= '0;
         rd_data_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         op_q        <= op_d;
         rd_data_q   <= rd_data_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state logic; RAM address and write data are loaded at acceptance
   // so they are already stable in the WR/RD cycle.
   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      op_d        = op_q;
      rd_data_d   = rd_data_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               sp_d = '0;
            end else if (cmd_valid) begin
               case (cmd_op)
                  OP_PUSH: begin
                     op_d = cmd_op;
                     if (full_w) begin
                        state_d = S_ERR;
                     end else begin
                        state_d     = S_WR;
                        mem_addr_d  = sp_q[ADDR_W-1:0];
                        mem_wdata_d = cmd_data;
                     end
                  end
                  OP_POP: begin
                     op_d = cmd_op;
                     if (empty_w) begin
                        state_d = S_ERR;
                     end else begin
                        state_d    = S_RD;
                        mem_addr_d = sp_m1[ADDR_W-1:0];
                     end
                  end
                  OP_REPLACE: begin
                     op_d = cmd_op;
                     if (empty_w) begin
                        state_d = S_ERR;
                     end else begin
                        state_d     = S_WR;
                        mem_addr_d  = sp_m1[ADDR_W-1:0];
                        mem_wdata_d = cmd_data;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_WR: begin
            if (op_q == OP_PUSH) sp_d = sp_q + SP_ONE;
            state_d = S_DONE;
         end
         S_RD:      state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            rd_data_d = mem_rdata;
            sp_d      = sp_m1;
            state_d   = S_DONE;
         end
         S_DONE:    state_d = S_IDLE;
         S_ERR: begin
            ovf_set = (op_q == OP_PUSH);
            unf_set = (op_q != OP_PUSH);
            state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE) || (state_q == S_ERR);
   assign mem_wren  = (state_q == S_WR);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rd_data   = rd_data_q;
   assign depth     = sp_q;
   assign full      = full_w;
   assign empty     = empty_w;

`ifdef PILHA_ERR_STICKY_EN
   logic ovf_q, unf_q;

   // Sticky error flags; a new error in the clear cycle wins over err_clr.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_set | (ovf_q & ~err_clr);
         unf_q <= unf_set | (unf_q & ~err_clr);
      end
   end

   assign err_ovf = ovf_q | ovf_set;
   assign err_unf = unf_q | unf_set;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_ovf        = ovf_set;
   assign err_unf        = unf_set;
`endif

endmodule

// File: tb/tb_pilha_ctrl.sv
// Bench for pilha_ctrl: a queue-based stack model plus a RAM model; one
// negedge process compares every output each cycle against the model.
module tb_pilha_ctrl;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

   logic              clock, reset, cmd_valid, cmd_ready, flush, err_clr, done;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data, rd_data, mem_wdata, mem_rdata;
   logic              err_ovf, err_unf, full, empty, mem_wren;
   logic [ADDR_W:0]   depth;
   logic [ADDR_W-1:0] mem_addr;

   int total = 0;
   int bad   = 0;

   pilha_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .flush(flush), .err_clr(err_clr),
      .done(done), .rd_data(rd_data), .err_ovf(err_ovf), .err_unf(err_unf),
      .depth(depth), .full(full), .empty(empty), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model: synchronous write, 1-cycle registered read.
   logic [DATA_W-1:0] ram [0:DEPTH-1];
   always @(posedge clock) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model state
   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] last_pop;
   logic [1:0]        pend_op;
   logic [DATA_W-1:0] pend_data;
   int                pend_acc;
   int                cyc = 0;
   int                lat;
   bit                pend = 0;
   bit                chk_en = 0;
   bit                st_ovf = 0, st_unf = 0;
   bit                fin, is_err, wr_now, ovf_now, unf_now, exp_ovf, exp_unf;

   // Per-cycle compare against the stack model.
   always @(negedge clock) begin
      cyc++;
      if (chk_en && !reset) begin
         fin = 0; is_err = 0; wr_now = 0; ovf_now = 0; unf_now = 0;
         if (pend) begin
            is_err = (pend_op == PUSH) ? (mq.size() == DEPTH) : (mq.size() == 0);
            lat    = is_err ? 1 : ((pend_op == POP) ? 3 : 2);
            fin    = (cyc == pend_acc + lat - 1);
            wr_now = !is_err && (pend_op != POP) && (cyc == pend_acc);
            ovf_now = fin && is_err && (pend_op == PUSH);
            unf_now = fin && is_err && (pend_op != PUSH);
         end
         chk1("done", done, fin);
         chk1("cmd_ready", cmd_ready, !pend);
         chk1("mem_wren", mem_wren, wr_now);
         if (wr_now) begin
            chkw("mem_addr", 32'(mem_addr),
                 (pend_op == PUSH) ? 32'(mq.size()) : 32'(mq.size() - 1));
            chkw("mem_wdata", 32'(mem_wdata), 32'(pend_data));
         end
         if (fin && !is_err) begin
            case (pend_op)
               PUSH:    mq.push_back(pend_data);
               REPL:    mq[mq.size()-1] = pend_data;
               default: last_pop = mq.pop_back();
            endcase
         end
`ifdef PILHA_ERR_STICKY_EN
         exp_ovf = st_ovf | ovf_now;
         exp_unf = st_unf | unf_now;
         st_ovf  = exp_ovf;
         st_unf  = exp_unf;
`else
         exp_ovf = ovf_now;
         exp_unf = unf_now;
`endif
         chk1("err_ovf", err_ovf, exp_ovf);
         chk1("err_unf", err_unf, exp_unf);
         chkw("depth", 32'(depth), 32'(mq.size()));
         chk1("full", full, mq.size() == DEPTH);
         chk1("empty", empty, mq.size() == 0);
         chkw("rd_data", 32'(rd_data), 32'(last_pop));
         if (fin) pend = 0;
      end
   end

   task automatic model_reset();
      mq.delete();
      last_pop = '0;
      pend = 0;
      st_ovf = 0;
      st_unf = 0;
   endtask

   // Issue one command from IDLE and wait (bounded) for its completion.
   task automatic do_cmd(input logic [1:0] op, input logic [DATA_W-1:0] d);
      @(posedge clock); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge clock); #1;
      cmd_valid = 1'b0; cmd_op = NOP;
      if (op != NOP) begin
         pend_op = op; pend_data = d; pend_acc = cyc + 1; pend = 1;
         for (int i = 0; i < 8 && pend; i++) @(negedge clock);
         if (pend) begin
            total++; bad++;
            $display("FAIL cmd_timeout: op %0d no done within 8 cycles", op);
            pend = 0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0;
      flush = 1'b0; err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk1("rst_cmd_ready", cmd_ready, 1'b1);
      chkw("rst_depth", 32'(depth), 32'd0);
      chk1("rst_empty", empty, 1'b1);
      chk1("rst_full", full, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err_ovf", err_ovf, 1'b0);
      chk1("rst_err_unf", err_unf, 1'b0);
      chkw("rst_rd_data", 32'(rd_data), 32'd0);
      chkw("rst_mem_addr", 32'(mem_addr), 32'd0);
      chkw("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk1("rst_mem_wren", mem_wren, 1'b0);
      reset = 1'b0;
      chk_en = 1;

      // Two pushes land at addresses 0 and 1.
      do_cmd(PUSH, 16'h1234);
      do_cmd(PUSH, 16'hBEEF);
      chkw("t1_ram0", 32'(ram[0]), 32'h1234);
      chkw("t1_ram1", 32'(ram[1]), 32'hBEEF);
      chkw("t1_depth", 32'(depth), 32'd2);

      // Pops come back in LIFO order.
      do_cmd(POP, '0);
      chkw("t2_pop1", 32'(rd_data), 32'hBEEF);
      do_cmd(POP, '0);
      chkw("t2_pop2", 32'(rd_data), 32'h1234);
      chkw("t2_depth", 32'(depth), 32'd0);
      chk1("t2_empty", empty, 1'b1);

      // Underflow on POP and REPLACE; rd_data holds the last popped word.
      do_cmd(POP, '0);
      do_cmd(REPL, 16'h0007);
      chkw("t4_rd_hold", 32'(rd_data), 32'h1234);
      chkw("t4_depth", 32'(depth), 32'd0);

      // Replace the top, then pop it; NOP does nothing.
      do_cmd(PUSH, 16'h0005);
      do_cmd(REPL, 16'h0009);
      do_cmd(NOP, 16'hFFFF);
      do_cmd(POP, '0);
      chkw("t5_pop", 32'(rd_data), 32'h0009);
      chkw("t5_depth", 32'(depth), 32'd0);

      // Flush wins over a simultaneous command.
      do_cmd(PUSH, 16'h0001);
      do_cmd(PUSH, 16'h0002);
      @(posedge clock); #1;
      flush = 1'b1; cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 16'hAAAA;
      @(posedge clock); #1;
      flush = 1'b0; cmd_valid = 1'b0; cmd_op = NOP;
      mq.delete();
      repeat (3) @(posedge clock);
      #1;
      chkw("t5_flush_depth", 32'(depth), 32'd0);

      // Fill to DEPTH, then overflow.
      for (int i = 0; i < DEPTH; i++) do_cmd(PUSH, 16'(16'h0100 + 3 * i));
      chk1("t3_full", full, 1'b1);
      do_cmd(PUSH, 16'hDEAD);
      chkw("t3_depth", 32'(depth), 32'd32);
      chkw("t3_ram31", 32'(ram[31]), 32'h015D);
      do_cmd(POP, '0);
      chkw("t3_pop", 32'(rd_data), 32'h015D);

      // Reset during WR of a PUSH aborts the write.
      @(posedge clock); #1;
      cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 16'h5555;
      @(posedge clock); #1;
      cmd_valid = 1'b0; cmd_op = NOP;
      chk_en = 0;
      chk1("t6_wren_before", mem_wren, 1'b1);
      reset = 1'b1;
      #1;
      chk1("t6_wren_drop", mem_wren, 1'b0);
      chkw("t6_depth", 32'(depth), 32'd0);
      chk1("t6_done", done, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      chk1("t6_done_later", done, 1'b0);
      chkw("t6_ram31", 32'(ram[31]), 32'h015D);
      reset = 1'b0;
      model_reset();
      chk_en = 1;

`ifdef PILHA_ERR_STICKY_EN
      for (int i = 0; i < DEPTH; i++) do_cmd(PUSH, 16'(i));
      do_cmd(PUSH, 16'h0BAD);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         chk1("t7_sticky_hold", err_ovf, 1'b1);
      end
      err_clr = 1'b1;
      @(posedge clock); #1;
      err_clr = 1'b0;
      st_ovf = 0;
      chk1("t7_sticky_clr", err_ovf, 1'b0);
`else
      do_cmd(POP, '0);
      err_clr = 1'b1;
      @(posedge clock); #1;
      err_clr = 1'b0;
      chk1("t7_pulse_gone", err_unf, 1'b0);
`endif
      repeat (2) @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pilha_ctrl.md
Name: pilha_ctrl

Overview:
- Stack controller that sequences the processor's stack memory (a synchronous single-port RAM, 1-cycle read latency).
- Serves PUSH / POP / REPLACE commands from the control unit over a valid/ready handshake.
- Owns the stack pointer and produces full/empty status and overflow/underflow errors.
- Sits between the control unit and the stack RAM; the RAM sees only this block.

Parameters:
- DATA_W, 16, stack word width.
- ADDR_W, 5, stack RAM address width.
- DEPTH, 32, number of usable entries; must be <= 2**ADDR_W and >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted (state IDLE).
- cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE (overwrite top of stack).
- cmd_data  in  DATA_W  write data for PUSH/REPLACE.
- flush  in  1  empties the stack (honoured in IDLE only).
- err_clr  in  1  clears sticky error flags (used only with PILHA_ERR_STICKY_EN).
- done  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  popped word; valid when done follows a POP, held until the next POP completes.
- err_ovf  out  1  PUSH attempted while full.
- err_unf  out  1  POP/REPLACE attempted while empty.
- depth  out  ADDR_W+1  current entry count.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- mem_addr  out  ADDR_W  stack RAM address.
- mem_wdata  out  DATA_W  stack RAM write data.
- mem_wren  out  1  stack RAM write enable.
- mem_rdata  in  DATA_W  stack RAM read data, valid 1 cycle after the address is presented.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE, sp=0, depth=0, empty=1, full=0, cmd_ready=1.
  - done=0, err_ovf=0, err_unf=0, rd_data=0, mem_addr=0, mem_wdata=0, mem_wren=0.
  - A reset mid-operation aborts the command: no write completes after reset asserts, and no done is produced.
- sp points to the next free slot; depth equals sp.
- States: IDLE, WR, RD, RD_WAIT, DONE, ERR.
- IDLE:
  - cmd_ready=1.
  - flush has priority: sp<=0, no done, and cmd_valid is ignored that cycle.
  - Otherwise a command is accepted on cmd_valid && cmd_ready; cmd_op and cmd_data are registered at acceptance.
  - PUSH: full -> ERR; else -> WR.
  - POP: empty -> ERR; else -> RD.
  - REPLACE: empty -> ERR; else -> WR.
  - NOP: no state change, no done.
- WR: mem_wren=1, mem_wdata=registered data.
  - PUSH: mem_addr=sp, sp<=sp+1.
  - REPLACE: mem_addr=sp-1, sp unchanged.
  - Next state DONE.
- RD: mem_addr=sp-1, mem_wren=0 -> RD_WAIT.
- RD_WAIT: rd_data<=mem_rdata, sp<=sp-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR:
  - done=1 for one cycle; set err_ovf (PUSH) or err_unf (POP/REPLACE).
  - sp and RAM are untouched -> IDLE.
- cmd_ready=0 in every state except IDLE; cmd_valid and flush are ignored outside IDLE.
- Latency, from the acceptance edge to the done cycle: PUSH/REPLACE 2 cycles, POP 3 cycles, error 1 cycle.
- Throughput: the earliest next acceptance is the cycle after done.
- mem_wren is high only in WR; mem_addr holds its last value outside WR/RD.
- full, empty and depth are combinational from sp.
- No wrap-around: sp never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: PILHA_ERR_STICKY_EN.
- Defined:
  - err_ovf/err_unf stay set once raised.
  - They clear only on reset or on an err_clr pulse.
  - If err_clr and a new error occur in the same cycle, the flag stays set.
- Undefined:
  - err_ovf/err_unf are one-cycle pulses coincident with done in ERR.
  - err_clr is ignored.

Test Plan:
- Reset, then PUSH 0x1234, 0xBEEF -> done 2 cycles after each acceptance; mem writes at addr 0 then 1; depth=2.
- Continuing from the previous state, POP twice -> rd_data=0xBEEF then 0x1234, done 3 cycles after each acceptance; depth=0, empty=1.
- PUSH 32 words with DEPTH=32 -> full=1; 33rd PUSH -> ERR, err_ovf=1, no mem_wren, depth stays 32.
- Empty stack, POP -> done after 1 cycle, err_unf=1; REPLACE 0x0007 on empty -> err_unf=1.
- PUSH 0x0005, REPLACE 0x0009, POP -> rd_data=0x0009, depth=0; flush with cmd_valid in IDLE -> depth=0, command dropped.
- Assert reset during WR of a PUSH -> mem_wren drops immediately, depth=0, no done.
- With PILHA_ERR_STICKY_EN, err_ovf holds through 5 cycles until err_clr.
